min_block_detect_cbfp: RTL
==========================

# min_block_detect_cbfp

Parametrised block-minimum detector for CBFP normalisation. Each cycle it reduces NUM_CH channels of 2×LANES leading-zero counts (real and imaginary lanes) to one minimum per channel, then accumulates those minima across a run-time selectable block of 1/2/4/8 valid beats. It sits between the butterfly LZC units and the CBFP shifter. At the end of every block it emits one registered shift amount per channel with a single-cycle valid strobe.

## Interface
- LZC_WIDTH, 5, bit width of one LZC value
- LANES, 8, LZC values per channel per cycle, for each of the real and imaginary parts; must be ≥1
- NUM_CH, 2, independent channels (e.g. add path, sub path); must be ≥1
- MAX_SHIFT, 20, clamp ceiling; used only when CBFP_MIN_CLAMP_EN is defined; must be < 2^LZC_WIDTH
- CNT_W, 8, width of the completed-block counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input beat qualifier
- lzc_re  in  NUM_CH*LANES*LZC_WIDTH  real LZCs; channel c, lane l at bits [(c*LANES+l)*LZC_WIDTH +: LZC_WIDTH]
- lzc_im  in  NUM_CH*LANES*LZC_WIDTH  imaginary LZCs, same packing
- blk_len_log2  in  2  block length = 2^blk_len_log2 valid beats (1, 2, 4, 8)
- min_out  out  NUM_CH*LZC_WIDTH  block minimum per channel; channel c at [c*LZC_WIDTH +: LZC_WIDTH]
- out_valid  out  1  one-cycle strobe: min_out updated this cycle
- blk_cnt  out  CNT_W  completed blocks, modulo 2^CNT_W
- busy  out  1  high while a block is partially accumulated

## Operation
- Stage 1 (registered):
  - s1_min[c] = unsigned minimum of the 2×LANES values of channel c.
  - s1_valid = in_valid.
  - The registers load every cycle; s1_min is don't-care when s1_valid = 0.
- Stage 2 accumulator, per channel, acting only when s1_valid = 1:
  - beat_cnt == 0: acc[c] ← s1_min[c].
  - otherwise: acc[c] ← min(acc[c], s1_min[c]).
- blk_len_log2:
  - Sampled into len_reg on the first beat of each block, i.e. when beat_cnt == 0 and s1_valid.
  - Changes mid-block are ignored until the next block.
  - For the first beat itself, the freshly sampled value governs the terminal test.
- Terminal beat (beat_cnt == 2^len − 1 with s1_valid):
  - min_out[c] ← min(acc[c], s1_min[c]); for a 1-beat block, min_out[c] ← s1_min[c].
  - out_valid ← 1, blk_cnt ← blk_cnt + 1 (wraps), beat_cnt ← 0.
- Non-terminal valid beat: beat_cnt ← beat_cnt + 1.
- beat_cnt is 3 bits wide.
- Beats with in_valid = 0 are gaps. They hold all state; blocks span gaps freely.
- busy = (beat_cnt != 0).
- min_out holds its value between blocks.
- Comparisons are unsigned. Ties are irrelevant because only the value is output.

## Timing
- Latency: from the input cycle of the terminal beat (edge T) to out_valid/min_out, 2 edges (visible after edge T+2).
- Throughput: one beat per cycle. Back-to-back blocks need no idle cycle, so out_valid may be high on consecutive cycles when blk_len_log2 = 0.
- Reset values:
  - min_out = 0, out_valid = 0, blk_cnt = 0, busy = 0
  - internal: s1_valid = 0, beat_cnt = 0, acc = 0, len_reg = 0
- Reset mid-block:
  - Discards the partial block; no out_valid is produced for it.
  - A beat presented in the same cycle that rst is high is discarded.
  - The first beat after rst deasserts starts a new block.
- Stage-1 contents in flight during reset are flushed (s1_valid cleared).

## Configuration
- CBFP_MIN_CLAMP_EN defined:
  - The value written to min_out is min(block_min, MAX_SHIFT).
  - Clamping is applied only at the output register; acc is unclamped.
- Not defined:
  - min_out is the raw block minimum.
  - MAX_SHIFT is unused; no clamp logic is generated.

## Test plan
- Defaults, blk_len_log2 = 0; per cycle, channel 0 all 31 except lzc_im lane 5 = 3, channel 1 all 7 → out_valid 2 cycles later, min_out = {7, 3}, blk_cnt = 1. Repeat 4 consecutive beats → 4 consecutive strobes, blk_cnt = 4.
- blk_len_log2 = 2; channel 0 beat minima 9, 4, 12, 6 with 2 gap cycles between beats 2 and 3 → exactly one strobe, 2 edges after beat 4, with min_out[0] = 4; busy high from the cycle after beat 1 until the terminal beat.
- blk_len_log2 = 3, changed to 0 after beat 2 → block still takes 8 beats; the next block is 1 beat long.
- Assert rst after beat 3 of a 4-beat block → no strobe, outputs return to reset values. A new 4-beat block with minima 10, 11, 12, 13 → min_out[0] = 10, blk_cnt = 1.
- CNT_W = 2; run 5 single-beat blocks → blk_cnt sequence 1, 2, 3, 0, 1.
- With CBFP_MIN_CLAMP_EN, MAX_SHIFT = 20, all inputs 31 → min_out = 20 per channel. Without the macro → 31.

Source files
------------

// File: rtl/min_block_detect_cbfp.sv
// Block-minimum detector for CBFP: per-channel min of 2*LANES LZCs, accumulated over 1/2/4/8 valid beats.
// Optional output clamp to MAX_SHIFT enabled by defining CBFP_MIN_CLAMP_EN.
module min_block_detect_cbfp #(
    parameter int LZC_WIDTH = 5,
    parameter int LANES     = 8,
    parameter int NUM_CH    = 2,
    parameter int MAX_SHIFT = 20,
    parameter int CNT_W     = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    input  logic [NUM_CH*LANES*LZC_WIDTH-1:0]   lzc_re,
    input  logic [NUM_CH*LANES*LZC_WIDTH-1:0]   lzc_im,
    input  logic [1:0]                          blk_len_log2,
    output logic [NUM_CH*LZC_WIDTH-1:0]         min_out,
    output logic                                out_valid,
    output logic [CNT_W-1:0]                    blk_cnt,
    output logic                                busy
);
    localparam int W = LZC_WIDTH;

    logic [NUM_CH-1:0][W-1:0] w_ch_min;
    logic [NUM_CH-1:0][W-1:0] r_s1_min;
    logic                     r_s1_valid;

    logic [NUM_CH-1:0][W-1:0] r_acc;
    logic [NUM_CH-1:0][W-1:0] w_acc_nxt;
    logic [NUM_CH-1:0][W-1:0] w_out_nxt;
    logic [NUM_CH-1:0][W-1:0] r_min_out;
    logic                     r_out_valid;
    logic [CNT_W-1:0]         r_blk_cnt;
    logic [2:0]               r_beat_cnt;
    logic [1:0]               r_len;

    logic                     w_first;
    logic [1:0]               w_len;
    logic [2:0]               w_term;
    logic                     w_last;

    // Stage 1 reduction: linear scan over real and imaginary lanes of each channel.
    always_comb begin
        w_ch_min = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_ch_min[c] = '1;
            for (int l = 0; l < LANES; l++) begin
                if (lzc_re[(c*LANES+l)*W +: W] < w_ch_min[c])
                    w_ch_min[c] = lzc_re[(c*LANES+l)*W +: W];
                if (lzc_im[(c*LANES+l)*W +: W] < w_ch_min[c])
                    w_ch_min[c] = lzc_im[(c*LANES+l)*W +: W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_min   <= '0;
        end else begin
            r_s1_valid <= in_valid;
            r_s1_min   <= w_ch_min;
        end
    end

    // The first beat of a block uses the live length so a 1-beat block terminates immediately.
    assign w_first = (r_beat_cnt == 3'd0);
    assign w_len   = w_first ? blk_len_log2 : r_len;
    assign w_term  = 3'((4'd1 << w_len) - 4'd1);
    assign w_last  = r_s1_valid && (r_beat_cnt == w_term);

    always_comb begin
        w_acc_nxt = '0;
        w_out_nxt = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_first || (r_s1_min[c] < r_acc[c]))
                w_acc_nxt[c] = r_s1_min[c];
            else
                w_acc_nxt[c] = r_acc[c];
`ifdef CBFP_MIN_CLAMP_EN
            if (w_acc_nxt[c] > W'(MAX_SHIFT))
                w_out_nxt[c] = W'(MAX_SHIFT);
            else
                w_out_nxt[c] = w_acc_nxt[c];
`else
            w_out_nxt[c] = w_acc_nxt[c];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= '0;
            r_min_out   <= '0;
            r_out_valid <= 1'b0;
            r_blk_cnt   <= '0;
            r_beat_cnt  <= '0;
            r_len       <= '0;
        end else begin
            r_out_valid <= 1'b0;
            if (r_s1_valid) begin
                r_acc <= w_acc_nxt;
                if (w_first)
                    r_len <= blk_len_log2;
                if (w_last) begin
                    r_min_out   <= w_out_nxt;
                    r_out_valid <= 1'b1;
                    r_blk_cnt   <= r_blk_cnt + 1'b1;
                    r_beat_cnt  <= '0;
                end else begin
                    r_beat_cnt  <= r_beat_cnt + 3'd1;
                end
            end
        end
    end

    assign min_out   = r_min_out;
    assign out_valid = r_out_valid;
    assign blk_cnt   = r_blk_cnt;
    assign busy      = (r_beat_cnt != 3'd0);

endmodule
